// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Results are computed at issue and committed when the busy countdown expires.
module mdu_hilo #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDUOp,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Issue handshake: an op is taken on a rising edge where Start=1 and Busy=0
  // and MDUOp names a real op; Start while Busy=1 is dropped, never queued.
  // Busy is a pure function of the counter register, so it never depends on Start.

  logic [CNT_W-1:0] cnt;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic [31:0]      pend_hi;
  logic [31:0]      pend_lo;
  logic             pend_wr;

  logic idle;
  logic accept;
  logic is_mul;
  logic is_div;
  logic is_mthi;
  logic is_mtlo;
  logic completing;

  always_comb begin
    idle       = (cnt == '0);
    accept     = Start && idle;
    is_mul     = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU);
    is_div     = (MDUOp == OP_DIV)  || (MDUOp == OP_DIVU);
    is_mthi    = (MDUOp == OP_MTHI);
    is_mtlo    = (MDUOp == OP_MTLO);
    completing = (cnt == CNT_ONE);
  end

  // Multiply: the low 64 bits of a product of sign-extended operands equal the
  // signed product, so one 64-bit multiplier serves both mult and multu.
  logic        mul_signed;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] prod;

  always_comb begin
    mul_signed = (MDUOp == OP_MULT);
    mul_a      = {{32{mul_signed & A[31]}}, A};
    mul_b      = {{32{mul_signed & B[31]}}, B};
    prod       = mul_a * mul_b;
  end

  // Divide on magnitudes, then restore signs: quotient negative when operand
  // signs differ, remainder follows the dividend. 0x80000000/-1 wraps to itself.
  logic        div_signed;
  logic        div_zero;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] div_q;
  logic [31:0] div_r;

  always_comb begin
    div_signed = (MDUOp == OP_DIV);
    div_zero   = (B == 32'd0);
    neg_a      = div_signed & A[31];
    neg_b      = div_signed & B[31];
    abs_a      = neg_a ? (~A + 32'd1) : A;
    abs_b      = neg_b ? (~B + 32'd1) : B;
    q_mag      = 32'd0;
    r_mag      = 32'd0;
    if (!div_zero) begin
      q_mag = abs_a / abs_b;
      r_mag = abs_a % abs_b;
    end
    div_q = (neg_a ^ neg_b) ? (~q_mag + 32'd1) : q_mag;
    div_r = neg_a ? (~r_mag + 32'd1) : r_mag;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (accept && is_mul) begin
      cnt <= MULT_LOAD;
    end else if (accept && is_div) begin
      cnt <= DIV_LOAD;
    end else if (!idle) begin
      cnt <= cnt - CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_wr <= 1'b0;
    end else if (accept && is_mul) begin
      pend_hi <= prod[63:32];
      pend_lo <= prod[31:0];
      pend_wr <= 1'b1;
    end else if (accept && is_div) begin
      pend_hi <= div_r;
      pend_lo <= div_q;
      pend_wr <= !div_zero;
    end
  end

  // Completion and mt* cannot coincide: mt* needs idle, completion needs cnt==1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else if (completing) begin
      if (pend_wr) begin
        hi_q <= pend_hi;
        lo_q <= pend_lo;
      end
    end else if (accept && is_mthi) begin
      hi_q <= A;
    end else if (accept && is_mtlo) begin
      lo_q <= A;
    end
  end

  assign Busy = !idle;
  assign HI   = hi_q;
  assign LO   = lo_q;

  logic unused_op_none;
  assign unused_op_none = (MDUOp == OP_NONE);

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: directed cases with literal expectations,
// then random traffic checked every cycle against a scheduled-result model.
module tb_mdu_hilo;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  // ---------------- clock / reset ----------------
  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] a     = 32'd0;
  logic [31:0] b     = 32'd0;
  logic [2:0]  op    = 3'd0;
  logic        start = 1'b0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  always #5 clk = ~clk;

  mdu_hilo #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .A     (a),
    .B     (b),
    .MDUOp (op),
    .Start (start),
    .Busy  (busy),
    .HI    (hi),
    .LO    (lo)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A result is scheduled to land N edges after issue; Busy is "a result is scheduled".
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [31:0] m_phi = 32'd0;
  logic [31:0] m_plo = 32'd0;
  bit          m_pwr = 1'b0;
  bit          m_pend = 1'b0;
  int          m_edge = 0;
  int          m_done_at = 0;

  function automatic void compute(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] rh, output logic [31:0] rl, output bit wr);
    longint          sx, sy, sp, sq, sr;
    longint unsigned up;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    rh = 32'd0; rl = 32'd0; wr = 1'b1;
    case (o)
      OP_MULT: begin
        sp = sx * sy;
        rh = sp[63:32]; rl = sp[31:0];
      end
      OP_MULTU: begin
        up = 64'(x) * 64'(y);
        rh = up[63:32]; rl = up[31:0];
      end
      OP_DIV: begin
        if (y == 32'd0) wr = 1'b0;
        else begin
          sq = sx / sy; sr = sx % sy;
          rl = sq[31:0]; rh = sr[31:0];
        end
      end
      default: begin
        if (y == 32'd0) wr = 1'b0;
        else begin
          rl = x / y; rh = x % y;
        end
      end
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hi = 32'd0; m_lo = 32'd0; m_pend = 1'b0; m_pwr = 1'b0; m_edge = 0;
    end else begin
      bit was_busy;
      was_busy = m_pend;
      m_edge++;
      if (m_pend && m_edge == m_done_at) begin
        if (m_pwr) begin
          m_hi = m_phi; m_lo = m_plo;
        end
        m_pend = 1'b0;
      end
      if (!was_busy && start) begin
        case (op)
          OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
            compute(op, a, b, m_phi, m_plo, m_pwr);
            m_pend = 1'b1;
            m_done_at = m_edge + ((op == OP_MULT || op == OP_MULTU) ? MULT_N : DIV_N);
          end
          OP_MTHI: m_hi = a;
          OP_MTLO: m_lo = a;
          default: ;
        endcase
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
      check("busy", {31'd0, busy}, {31'd0, m_pend});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; op = OP_NONE; a = $urandom; b = $urandom;
  endtask

  // Returns on the first negedge with Busy low; n counts the Busy-high negedges seen.
  task automatic wait_idle(output int n);
    bit done;
    n = 0; done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
      else n++;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL wait_idle: got busy after 100 cycles expected idle");
    end
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin : main
    int n;
    int nb;
    repeat (3) @(posedge clk);
    #2;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;

    issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n);
    check("mult_busy_len", n, MULT_N);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);

    issue(OP_MULTU, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n);
    check("multu_hi", hi, 32'h0000_0002);
    check("multu_lo", lo, 32'hFFFF_FFFA);

    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    check("div_busy_len", n, DIV_N);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    issue(OP_DIVU, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    check("divu_lo", lo, 32'h7FFF_FFFC);
    check("divu_hi", hi, 32'h0000_0001);

    issue(OP_MTHI, 32'h11, 32'd0);
    issue(OP_MTLO, 32'h22, 32'd0);
    issue(OP_DIV, 32'd1234, 32'd0);
    wait_idle(n);
    check("divz_busy_len", n, DIV_N);
    check("divz_hi", hi, 32'h11);
    check("divz_lo", lo, 32'h22);

    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    check("ovf_lo", lo, 32'h8000_0000);
    check("ovf_hi", hi, 32'h0);

    issue(OP_RSVD, 32'h77, 32'h1);
    issue(OP_NONE, 32'h77, 32'h1);
    @(negedge clk);
    check("rsvd_busy", {31'd0, busy}, 32'd0);
    check("rsvd_lo", lo, 32'h8000_0000);

    // Strobes while busy must neither write nor restart the countdown.
    issue(OP_DIV, 32'd100, 32'd7);
    nb = 0;
    for (int i = 0; i < 4; i++) begin
      op = (i < 2) ? OP_MTLO : OP_MULT; a = 32'h55; b = 32'd3; start = 1'b1;
      @(negedge clk);
      if (busy) nb++;
    end
    start = 1'b0; op = OP_NONE;
    wait_idle(n);
    check("ign_busy_len", nb + n, DIV_N);
    check("ign_lo", lo, 32'd14);
    check("ign_hi", hi, 32'd2);
    issue(OP_MTHI, 32'hAB, 32'd0);
    @(negedge clk);
    check("b2b_mthi", hi, 32'hAB);
    check("b2b_lo", lo, 32'd14);

    // Asynchronous reset in the middle of a divide.
    issue(OP_DIV, 32'd1000, 32'd3);
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    #2 reset = 1'b0;
    repeat (15) @(negedge clk);
    check("arst_late_hi", hi, 32'd0);
    check("arst_late_lo", lo, 32'd0);

    // Random traffic, including strobes while busy and divide corner operands.
    for (int i = 0; i < 1500; i++) begin
      int sel;
      @(negedge clk);
      #1;
      op = 3'($urandom_range(0, 7));
      start = ($urandom_range(0, 3) != 0);
      a = $urandom;
      b = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = 32'($urandom_range(1, 9));
      else if (sel == 3) b = -32'($urandom_range(1, 9));
    end
    start = 1'b0; op = OP_NONE;
    wait_idle(n);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #300000;
    bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers for the 5-stage MIPS pipeline.
- Sits in the E stage beside the ALU. Operand A comes from forwarded rs; operand B comes from forwarded rt.
- Issues mult/multu/div/divu/mthi/mtlo and holds the results in HI/LO.
- Exposes Busy so the hazard unit can stall mult/div/mf*/mt* instructions in D.

Parameters:
MULT_CYCLES, 5, cycles Busy stays high after a mult/multu issue (must be >=1)
DIV_CYCLES, 10, cycles Busy stays high after a div/divu issue (must be >=1)

Ports:
clk  input  1  pipeline clock, rising-edge
reset  input  1  asynchronous, active-high; clears all state
A  input  32  operand 1 (rs value, forwarded)
B  input  32  operand 2 (rt value, forwarded)
MDUOp  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
Start  input  1  issue strobe; qualifies MDUOp this cycle
Busy  output  1  operation in flight
HI  output  32  HI register
LO  output  32  LO register

Behaviour:
- Reset (async, active-high):
  - HI=0, LO=0, Busy=0, counter=0; the pending result is discarded.
  - Reset mid-operation aborts the operation; HI/LO stay 0 after release.
- Issue acceptance:
  - An issue is accepted only when Start=1, Busy=0 and MDUOp is in 1..6.
  - Start with Busy=1 is ignored; it does not restart or queue. The hazard unit guarantees no such issue, and the bench checks that state is unaffected.
- mult/multu issue:
  - At the accepting edge, compute the 64-bit product into internal pending registers: signed for mult, unsigned for multu. A and B are not needed after that edge.
  - Load counter with MULT_CYCLES.
- div/divu issue:
  - Quotient goes to pending LO, remainder to pending HI.
  - Signed div truncates toward zero; the remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - Load counter with DIV_CYCLES.
- Divide by zero (B=0):
  - The operation still takes DIV_CYCLES cycles with Busy high.
  - At completion HI/LO keep their previous values; no write.
- Counter and Busy:
  - Busy = (counter != 0); it is a registered output with no combinational path from Start.
  - The counter decrements once per edge while nonzero.
  - On the edge where the counter goes 1->0, pending HI/LO are written.
  - Busy is therefore high for exactly N cycles after the issue edge, and the new HI/LO are visible in the first cycle Busy is low.
- mthi/mtlo:
  - Accepted only when Busy=0.
  - HI<=A or LO<=A at that edge, visible the next cycle. Busy stays 0.
  - With Start=1 and Busy=1 they are ignored.
- MDUOp 0 or 7 with Start=1: no effect.
- HI/LO hold between writes; they are never modified while Busy=1 except at the completion edge.
- Back-to-back issue: a new mult/div may be accepted in the first cycle Busy=0, i.e. the same cycle the previous result becomes visible.

Test Plan:
- Reset: assert reset asynchronously (mid-cycle) during a div -> HI=0, LO=0, Busy=0 immediately; after release HI/LO remain 0 and no late write occurs.
- Signed mult: A=0xFFFFFFFE (-2), B=3, mult -> Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- Unsigned mult with the same operands: multu -> HI=0x00000002, LO=0xFFFFFFFA.
- Signed div: A=-7 (0xFFFFFFF9), B=2, div -> Busy high 10 cycles; then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- Unsigned div with the same operands: divu -> LO=0x7FFFFFFC, HI=1.
- Divide by zero and overflow: preload HI=0x11, LO=0x22 via mthi/mtlo, then div with B=0 -> Busy 10 cycles, HI=0x11, LO=0x22 unchanged. Then div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- Ignored issues and back-to-back: while Busy=1, drive Start with mtlo A=0x55 and with a new mult -> LO/HI and the remaining count are unaffected. An mthi A=0xAB in the first Busy=0 cycle -> HI=0xAB next cycle.
